rom_access_arbiter: RTL and testbench
=====================================

Name: rom_access_arbiter

Overview:
- Shares the single asynchronous read-only program/constant memory between two requesters: the instruction fetch (IF) port and the load (LD) port.
- LD is the default winner; an IF-starvation counter bounds IF wait time.
- Grants at most one access per cycle and samples the combinational ROM data in the grant cycle.
- Returns a registered response one cycle later, with alignment and range checking.
- Sits between the CPU fetch/load units and the ROM.

Parameters:
WIDTH, 32, data and address width in bits.
DEPTH, 2048, number of ROM words; valid byte addresses are 0 .. 4*DEPTH-1.
MAX_WAIT, 4, consecutive IF denials after which IF is forced to win (>=1).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
if_req  input  1  IF request; held with if_addr stable until if_gnt.
if_addr  input  WIDTH  IF byte address.
if_gnt  output  1  combinational; IF request accepted this cycle.
if_rvalid  output  1  registered; IF response valid (one-cycle pulse).
if_rdata  output  WIDTH  registered IF read data.
if_err  output  1  registered; IF access misaligned or out of range.
ld_req  input  1  LD request; held with ld_addr stable until ld_gnt.
ld_addr  input  WIDTH  LD byte address.
ld_gnt  output  1  combinational; LD request accepted this cycle.
ld_rvalid  output  1  registered; LD response valid (one-cycle pulse).
ld_rdata  output  WIDTH  registered LD read data.
ld_err  output  1  registered; LD access misaligned or out of range.
rom_address  output  WIDTH  byte address to ROM; combinational from the granted port, 0 when idle.
rom_rdata  input  WIDTH  asynchronous ROM read data for rom_address.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high on clock; ports named clock and reset.
- Reset values: if_rvalid, ld_rvalid, if_err, ld_err = 0; if_rdata, ld_rdata = 0; starve counter = 0.
- Reset mid-operation: a response due on the next cycle is discarded (rvalid stays 0). Requesters must re-issue.
- Grants are combinational, so requesters can issue back-to-back.
- Arbitration each cycle:
  - neither req: no grant, rom_address = 0.
  - only one req: that port is granted.
  - both req and starve < MAX_WAIT: LD granted; starve increments.
  - both req and starve == MAX_WAIT: IF granted.
- Starve counter:
  - cleared to 0 on any cycle IF is granted, or when if_req is low.
  - saturates at MAX_WAIT.
  - counter width is clog2(MAX_WAIT+1).
- Grant outputs: if_gnt and ld_gnt are mutually exclusive. rom_address = granted port's address.
- Access check on the granted address:
  - misaligned if addr[1:0] != 0.
  - out of range if addr[WIDTH-1:2] >= DEPTH.
  - either condition → err = 1 and rdata = 0; the ROM value is ignored.
- Latency: fixed 1 cycle.
  - On the edge ending a grant cycle, the granted port's rvalid <= 1, rdata <= rom_rdata (or 0 on error), err <= check result.
  - The non-granted port's rvalid and err <= 0.
  - A port's rdata holds its last value while its rvalid = 0.
- Throughput: one access per cycle in total. Back-to-back grants to the same port produce consecutive rvalid pulses.
- No backpressure on responses: requesters must accept an rvalid pulse in the cycle it appears.
- Request withdrawal: a req dropped before its grant is legal. No state is retained, and nothing is issued to the ROM.

Test Plan:
1. Reset, then IF only, if_addr=0x0000_0010 with ROM word 4=0xDEADBEEF → if_gnt=1 in the same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, if_err=0; all LD outputs stay 0.
2. IF and LD both held high continuously, MAX_WAIT=4 → grant sequence LD,LD,LD,LD,IF repeating; the IF grant falls in the 5th cycle; ld_rvalid/if_rvalid pulses follow each grant by one cycle.
3. LD ld_addr=0x0000_0006 → ld_gnt=1; next cycle ld_rvalid=1, ld_err=1, ld_rdata=0. Then ld_addr=0x0000_2000 (word 2048) → ld_err=1. Then ld_addr=0x0000_1FFC → ld_err=0, ld_rdata=ROM[2047].
4. IF streams 8 consecutive addresses 0x0,0x4,...,0x1C with no LD → if_gnt high 8 cycles; if_rvalid high 8 consecutive cycles with matching data in order.
5. Assert reset in the cycle LD is granted → next cycle ld_rvalid=0, all outputs 0, starve counter 0. After release, both reqs → LD wins first.
6. IF denied 3 cycles, then if_req drops 1 cycle, then both reqs resume → starve restarts from 0; IF granted only after 4 further LD grants.

Source files
------------

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one async ROM between IF and LD ports with bounded IF starvation
module rom_access_arbiter #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 2048,
    parameter int MAX_WAIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_err,
    input  logic             ld_req,
    input  logic [WIDTH-1:0] ld_addr,
    output logic             ld_gnt,
    output logic             ld_rvalid,
    output logic [WIDTH-1:0] ld_rdata,
    output logic             ld_err,
    output logic [WIDTH-1:0] rom_address,
    input  logic [WIDTH-1:0] rom_rdata
);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] MAX_W = SW'(MAX_WAIT);
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    logic [SW-1:0]    starve;
    logic [SW-1:0]    starve_next;
    logic             bad;
    logic [WIDTH-1:0] data;

    // LD wins by default; IF wins alone or once it has been denied MAX_WAIT times in a row
    always_comb begin
        if_gnt      = if_req & (~ld_req | (starve == MAX_W));
        ld_gnt      = ld_req & ~if_gnt;
        rom_address = if_gnt ? if_addr : ld_gnt ? ld_addr : '0;
        bad         = (|rom_address[1:0]) | ({2'b00, rom_address[WIDTH-1:2]} >= DEPTH_W);
        data        = bad ? '0 : rom_rdata;
        starve_next = (~if_req | if_gnt) ? '0 : (starve == MAX_W) ? MAX_W : starve + 1'b1;
    end

    // starvation counter and one-cycle registered responses
    always_ff @(posedge clock) begin
        if (reset) begin
            starve    <= '0;
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            ld_rvalid <= 1'b0;
            ld_err    <= 1'b0;
            ld_rdata  <= '0;
        end else begin
            starve    <= starve_next;
            if_rvalid <= if_gnt;
            if_err    <= if_gnt & bad;
            ld_rvalid <= ld_gnt;
            ld_err    <= ld_gnt & bad;
            if (if_gnt) if_rdata <= data;
            if (ld_gnt) ld_rdata <= data;
        end
    end
endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter: directed plan plus randomized traffic against a behavioural model
module tb_rom_access_arbiter;
    localparam int D  = 2048;
    localparam int MW = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, ld_req;
    logic [31:0] if_addr, ld_addr;
    logic        if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err;
    logic [31:0] if_rdata, ld_rdata, rom_address, rom_rdata;
    logic [31:0] mem [D];

    int          total = 0;
    int          bad = 0;
    int          wait_n = 0;
    logic [31:0] e_if_rd = 0;
    logic [31:0] e_ld_rd = 0;
    bit          g_if, g_ld;

    always #5 clock = ~clock;

    assign rom_rdata = ((rom_address >> 2) < 32'(D)) ? mem[rom_address[12:2]] : (32'hBAD0_0000 ^ rom_address);

    rom_access_arbiter #(.WIDTH(32), .DEPTH(D), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .rom_address(rom_address), .rom_rdata(rom_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock: drive, check grants, cross the edge, check responses, advance the model
    task automatic step(input bit rst, input bit ir, input logic [31:0] ia, input bit lr, input logic [31:0] la);
        bit eif, eld, ebad;
        logic [31:0] ea, ed;
        reset = rst; if_req = ir; if_addr = ia; ld_req = lr; ld_addr = la;
        #1;
        eif  = ir && (!lr || wait_n >= MW);
        eld  = lr && !eif;
        ea   = eif ? ia : eld ? la : 32'h0;
        ebad = (ea % 4 != 0) || (ea / 4 >= D);
        ed   = ebad ? 32'h0 : mem[ea[12:2]];
        chk("if_gnt", {31'b0, if_gnt}, {31'b0, eif});
        chk("ld_gnt", {31'b0, ld_gnt}, {31'b0, eld});
        chk("rom_address", rom_address, ea);
        g_if = if_gnt;
        g_ld = ld_gnt;
        @(posedge clock);
        #1;
        if (rst) begin
            wait_n = 0; e_if_rd = 0; e_ld_rd = 0;
        end else begin
            if (eif) e_if_rd = ed;
            if (eld) e_ld_rd = ed;
            wait_n = (!ir || eif) ? 0 : (wait_n < MW ? wait_n + 1 : MW);
        end
        chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, !rst && eif});
        chk("if_err", {31'b0, if_err}, {31'b0, !rst && eif && ebad});
        chk("if_rdata", if_rdata, e_if_rd);
        chk("ld_rvalid", {31'b0, ld_rvalid}, {31'b0, !rst && eld});
        chk("ld_err", {31'b0, ld_err}, {31'b0, !rst && eld && ebad});
        chk("ld_rdata", ld_rdata, e_ld_rd);
        @(negedge clock);
    endtask

    function automatic logic [31:0] rand_addr();
        int k = $urandom_range(9);
        if (k == 0) return ($urandom_range(D - 1) << 2) | $urandom_range(1, 3);
        if (k == 1) return 32'(D * 4) + ($urandom_range(4095) << 2);
        if (k == 2) return 32'(D * 4 - 4);
        return $urandom_range(D - 1) << 2;
    endfunction

    initial begin
        bit ir, lr;
        logic [31:0] ia, la;
        for (int i = 0; i < D; i++) mem[i] = $urandom;
        mem[4] = 32'hDEADBEEF;
        reset = 1; if_req = 0; ld_req = 0; if_addr = 0; ld_addr = 0;
        @(negedge clock);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // IF only single read
        step(0, 1, 32'h10, 0, 0);
        chk("t1_data", if_rdata, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0);
        // both held: LD x4 then IF
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 32'h40, 1, 32'h80);
            chk("t2_seq", {31'b0, g_if}, {31'b0, (k % 5) == 4});
        end
        step(0, 0, 0, 0, 0);
        // error cases and top word
        step(0, 0, 0, 1, 32'h6);
        chk("t3_mis_err", {31'b0, ld_err}, 32'h1);
        step(0, 0, 0, 1, 32'h2000);
        chk("t3_oor_err", {31'b0, ld_err}, 32'h1);
        step(0, 0, 0, 1, 32'h1FFC);
        chk("t3_top_data", ld_rdata, mem[2047]);
        // IF stream
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 32'(k * 4), 0, 0);
            chk("t4_stream", if_rdata, mem[k]);
        end
        // reset during an LD grant
        step(0, 1, 32'h20, 1, 32'h24);
        step(1, 1, 32'h20, 1, 32'h24);
        step(0, 1, 32'h20, 1, 32'h24);
        chk("t5_ld_first", {31'b0, g_ld}, 32'h1);
        step(1, 0, 0, 0, 0);
        // starvation restart after IF withdrawal
        for (int k = 0; k < 3; k++) step(0, 1, 32'h30, 1, 32'h34);
        step(0, 0, 0, 1, 32'h34);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 32'h30, 1, 32'h34);
            chk("t6_restart", {31'b0, g_if}, {31'b0, k == 4});
        end
        // randomized traffic obeying hold-until-grant, with occasional withdrawal and reset
        ir = 0; lr = 0; ia = 0; la = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!ir || g_if) begin ir = ($urandom_range(9) < 7); ia = rand_addr(); end
            else if ($urandom_range(19) == 0) ir = 0;
            if (!lr || g_ld) begin lr = ($urandom_range(9) < 6); la = rand_addr(); end
            else if ($urandom_range(19) == 0) lr = 0;
            g_if = 0; g_ld = 0;
            step($urandom_range(99) == 0, ir, ia, lr, la);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
